load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the data-memory port: accepts load/store/copy requests from the
//  core over a valid/ready handshake and drives mem_read/mem_write/addr/wdata.
//  Captures the 1-cycle-latency registered read data and returns it as a one-cycle response.
//  Sits between the core datapath (MEM stage) and the 50x8 data memory.
// PARAMETERS
//  ADDR_W     6   address width; all address arithmetic wraps modulo 2**ADDR_W
//  DATA_W     8   data width
//  MEM_DEPTH  50  number of valid memory locations (used only with LSU_BOUNDS_CHECK_EN)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous reset, active-high
//  req_valid  in   1       request present
//  req_ready  out  1       1 only in IDLE; transfer = req_valid & req_ready at posedge
//  req_op     in   2       00 LOAD, 01 STORE, 10 COPY, 11 reserved (treated as LOAD)
//  req_addr   in   ADDR_W  LOAD/STORE address; COPY destination base
//  req_src    in   ADDR_W  COPY source base (ignored otherwise)
//  req_len    in   ADDR_W  COPY byte count (ignored otherwise)
//  req_wdata  in   DATA_W  STORE data
//  resp_valid out  1       one-cycle completion pulse (no backpressure)
//  resp_data  out  DATA_W  LOAD: read byte; STORE: 0; COPY: bytes copied
//  resp_err   out  1       out-of-range access (0 when LSU_BOUNDS_CHECK_EN is undefined)
//  mem_read   out  1       read strobe to memory
//  mem_write  out  1       write strobe to memory
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid the cycle after mem_read was sampled
// BEHAVIOUR
//  - Reset (async): state IDLE; req_ready=1; resp_valid, resp_err, mem_read, mem_write=0;
//    resp_data, mem_addr, mem_wdata=0. Reset mid-operation aborts; completed writes persist.
//  - Memory strobes, addr, and wdata are registered outputs. At most one of mem_read/mem_write is high.
//  - FSM: IDLE, RD, RD_WAIT, WR, RESP.
//  - LOAD (accept edge t0): cycle t1 in RD with mem_read=1 and mem_addr=req_addr; cycle t2 in
//    RD_WAIT, where mem_rdata is latched at t2 end. resp_valid=1 with resp_data=byte in cycle t3
//    (RESP). IDLE/req_ready=1 in t4.
//  - STORE: cycle t1 in WR with mem_write=1, addr, wdata; resp_valid=1 with resp_data=0 in t2.
//    IDLE in t3.
//  - COPY: for i=0..len-1: RD(src+i), RD_WAIT (latch byte), WR(dst+i), i.e. 3 cycles per byte.
//    Then RESP with resp_data=len. Forward order, byte at a time, so overlapping dst>src
//    replicates the leading bytes (defined, not an error).
//  - COPY with len=0: no memory strobes; resp_valid with resp_data=0 the cycle after accept.
//  - Address wrap: src+i and dst+i are truncated to ADDR_W bits (63+1 -> 0).
//  - req_* is sampled only at accept; later changes have no effect. req_valid while busy waits.
//  - resp_valid is high exactly one cycle per accepted request. req_ready is 0 in that cycle.
// CONFIGURATION
//  LSU_BOUNDS_CHECK_EN defined: any access with address >= MEM_DEPTH issues no strobe.
//   - LOAD/STORE: resp_err=1, resp_data=0.
//   - COPY: abort at the first out-of-range src or dst byte, resp_err=1, resp_data=bytes done.
//  Undefined: no check; addresses pass through unchanged; resp_err is tied to 0.
// STRUCTURE
//  Package lsu_pkg: op encodings (OP_LOAD/OP_STORE/OP_COPY), FSM state enum, and MEM_DEPTH
//  default. One sub-module: lsu_copy_ctr, which holds the byte index, wrapped src/dst address
//  generation, and the done flag. Everything else stays in the top module.
// TESTING
//  - rst high mid-COPY: all outputs 0 immediately (async); req_ready=1 after release.
//  - STORE addr=5 wdata=8'hA5, then LOAD addr=5: mem_write in t1, resp_data=8'hA5 in t3 of the LOAD.
//  - COPY src=0 dst=10 len=4 over memory 1,2,3,4: memory[10..13]=1..4 and resp_data=4,
//    with resp_valid 13 cycles after accept.
//  - COPY len=0: resp_valid the next cycle with resp_data=0 and no strobes. req_valid held
//    while busy: second request accepted only after RESP.
//  - COPY src=62 dst=20 len=3: reads addresses 62,63,0 (wrap).
//  - LSU_BOUNDS_CHECK_EN: LOAD addr=50 gives resp_err=1 with no mem_read. COPY src=48 len=4
//    aborts with resp_data=2, resp_err=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: op encodings, FSM states, sizing defaults and range helper shared by the load/store unit
package lsu_pkg;
  localparam int LSU_ADDR_W = 6;
  localparam int LSU_DATA_W = 8;
  localparam int LSU_MEM_DEPTH = 50;
  typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_STORE = 2'b01, OP_COPY = 2'b10, OP_RSVD = 2'b11} lsu_op_e;
  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} lsu_state_e;
  function automatic logic out_of_range(input int addr, input int depth);
    return addr >= depth;
  endfunction
endpackage

// File: rtl/lsu_copy_ctr.sv
// lsu_copy_ctr: COPY byte index (clk, rst, load/inc in; idx, wrapped src_addr/dst_addr, done out)
module lsu_copy_ctr #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] idx,
  output logic [ADDR_W-1:0] src_addr,
  output logic [ADDR_W-1:0] dst_addr,
  output logic              done
);
  logic [ADDR_W-1:0] src_q, dst_q, len_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx <= '0;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
    end else if (load) begin
      idx <= '0;
      src_q <= src_base;
      dst_q <= dst_base;
      len_q <= len;
    end else if (inc) idx <= idx + 1'b1;
  assign src_addr = src_q + idx;
  assign dst_addr = dst_q + idx;
  assign done = idx == len_q;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: valid/ready LOAD/STORE/COPY initiator driving registered mem_read/mem_write/mem_addr/mem_wdata to a 1-cycle-latency memory and returning resp_valid/resp_data/resp_err; LSU_BOUNDS_CHECK_EN enables the MEM_DEPTH range check
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W,
  parameter int MEM_DEPTH = LSU_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_src,
  input  logic [ADDR_W-1:0] req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  lsu_state_e state, state_n;
  lsu_op_e op_q;
  logic rd_n, wr_n, err_n, load, inc, done;
  logic [ADDR_W-1:0] addr_n, idx, src_addr, dst_addr;
  logic [DATA_W-1:0] wdata_n, data_n;
  function automatic logic oob(input logic [ADDR_W-1:0] a);
    return CHK && out_of_range(int'(a), MEM_DEPTH);
  endfunction
  lsu_copy_ctr #(.ADDR_W(ADDR_W)) u_ctr (
    .clk(clk),
    .rst(rst),
    .load(load),
    .inc(inc),
    .src_base(req_src),
    .dst_base(req_addr),
    .len(req_len),
    .idx(idx),
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .done(done)
  );
  assign req_ready = state == IDLE;
  always_comb begin
    state_n = state;
    rd_n = 1'b0;
    wr_n = 1'b0;
    err_n = 1'b0;
    load = 1'b0;
    inc = 1'b0;
    addr_n = mem_addr;
    wdata_n = mem_wdata;
    data_n = resp_data;
    case (state)
      IDLE: if (req_valid) begin
        load = req_op == OP_COPY;
        data_n = '0;
        err_n = req_op == OP_COPY ? req_len != '0 && (oob(req_src) || oob(req_addr)) : oob(req_addr);
        rd_n = !err_n && (req_op == OP_COPY ? req_len != '0 : req_op != OP_STORE);
        wr_n = !err_n && req_op == OP_STORE;
        addr_n = req_op == OP_COPY ? req_src : req_addr;
        wdata_n = req_op == OP_STORE ? req_wdata : mem_wdata;
        state_n = rd_n ? RD : wr_n ? WR : RESP;
      end
      RD: state_n = RD_WAIT;
      RD_WAIT: begin
        wr_n = op_q == OP_COPY;
        inc = wr_n;
        addr_n = wr_n ? dst_addr : mem_addr;
        wdata_n = wr_n ? mem_rdata : mem_wdata;
        data_n = wr_n ? resp_data : mem_rdata;
        state_n = wr_n ? WR : RESP;
      end
      WR: begin
        err_n = op_q == OP_COPY && !done && (oob(src_addr) || oob(dst_addr));
        rd_n = op_q == OP_COPY && !done && !err_n;
        addr_n = rd_n ? src_addr : mem_addr;
        data_n = op_q == OP_COPY ? DATA_W'(idx) : '0;
        state_n = rd_n ? RD : RESP;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      op_q <= OP_LOAD;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      resp_valid <= 1'b0;
      resp_err <= 1'b0;
      resp_data <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) op_q <= lsu_op_e'(req_op);
      mem_read <= rd_n;
      mem_write <= wr_n;
      mem_addr <= addr_n;
      mem_wdata <= wdata_n;
      resp_valid <= state_n == RESP;
      resp_err <= err_n;
      resp_data <= data_n;
    end
endmodule
